// File: rtl/toy_regfile_wb_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : toy_regfile_wb_arbiter_if                             |
// | Brief    : Writeback request bus from EUs/load/CSR to arbiter.   |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
interface toy_regfile_wb_arbiter_if #(
    parameter int REQ_NUM          = 6,
    parameter int PHY_REG_ID_WIDTH = 6,
    parameter int REG_WIDTH        = 32
);
    logic [REQ_NUM-1:0]                       v_req_vld;
    logic [REQ_NUM-1:0][PHY_REG_ID_WIDTH-1:0] v_req_index;
    logic [REQ_NUM-1:0][REG_WIDTH-1:0]        v_req_data;
    logic [REQ_NUM-1:0]                       v_req_rdy;

    modport master (
        output v_req_vld,
        output v_req_index,
        output v_req_data,
        input  v_req_rdy
    );

    modport slave (
        input  v_req_vld,
        input  v_req_index,
        input  v_req_data,
        output v_req_rdy
    );
endinterface
`default_nettype wire

// File: rtl/toy_regfile_wb_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : toy_regfile_wb_arbiter                                |
// | Brief    : Round-robin packing of writeback requests onto the    |
// |            physical regfile write ports, with reg-0 filtering.   |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module toy_regfile_wb_arbiter #(
    parameter int REQ_NUM          = 6,
    parameter int WR_PORT_NUM      = 4,
    parameter int MODE             = 0,
    parameter int PHY_REG_ID_WIDTH = 6,
    parameter int REG_WIDTH        = 32
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    toy_regfile_wb_arbiter_if.slave                    req_if,
    input  logic                                       wb_stall,
    output logic [WR_PORT_NUM-1:0]                     v_wr_en,
    output logic [WR_PORT_NUM-1:0][PHY_REG_ID_WIDTH-1:0] v_wr_reg_index,
    output logic [WR_PORT_NUM-1:0][REG_WIDTH-1:0]      v_wr_reg_data,
    output logic [31:0]                                wr_cnt,
    output logic [31:0]                                drop_cnt
);
    localparam int c_ptr_w  = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
    localparam int c_sum_w  = c_ptr_w + 1;
    localparam int c_port_w = (WR_PORT_NUM > 1) ? $clog2(WR_PORT_NUM) : 1;
    localparam int c_cnt_w  = $clog2(REQ_NUM + 1);

    logic [c_ptr_w-1:0]                           rr_ptr_q, rr_ptr_d;
    logic [WR_PORT_NUM-1:0]                       wr_en_q, wr_en_d;
    logic [WR_PORT_NUM-1:0][PHY_REG_ID_WIDTH-1:0] wr_idx_q, wr_idx_d;
    logic [WR_PORT_NUM-1:0][REG_WIDTH-1:0]        wr_data_q, wr_data_d;
    logic [31:0]                                  wr_cnt_q, wr_cnt_d;
    logic [31:0]                                  drop_cnt_q, drop_cnt_d;

    logic [REQ_NUM-1:0]  is_drop;
    logic [REQ_NUM-1:0]  rdy;
    logic [c_cnt_w-1:0]  grant_cnt;
    logic [c_cnt_w-1:0]  drop_num;
    logic [c_ptr_w-1:0]  last_grant;
    logic [c_sum_w-1:0]  scan_sum;
    logic [c_ptr_w-1:0]  scan_pos;
    logic [c_port_w-1:0] port_sel;
    logic [32:0]         wr_sum;
    logic [32:0]         drop_sum;

    // Reg-0 writes in INT mode are acknowledged but never reach a port.
    always_comb begin
        is_drop = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            if (MODE == 0 && req_if.v_req_vld[i] && req_if.v_req_index[i] == '0) begin
                is_drop[i] = 1'b1;
            end
        end
    end

    always_comb begin
        rdy        = '0;
        grant_cnt  = '0;
        drop_num   = '0;
        last_grant = rr_ptr_q;
        scan_sum   = '0;
        scan_pos   = '0;
        port_sel   = '0;
        wr_en_d    = '0;
        wr_idx_d   = wr_idx_q;
        wr_data_d  = wr_data_q;
        if (rst_n && !wb_stall) begin
            for (int s = 0; s < REQ_NUM; s++) begin
                scan_sum = {1'b0, rr_ptr_q} + c_sum_w'(s);
                if (scan_sum >= c_sum_w'(REQ_NUM)) begin
                    scan_sum = scan_sum - c_sum_w'(REQ_NUM);
                end
                scan_pos = scan_sum[c_ptr_w-1:0];
                if (is_drop[scan_pos]) begin
                    rdy[scan_pos] = 1'b1;
                    drop_num      = drop_num + c_cnt_w'(1);
                end else if (req_if.v_req_vld[scan_pos] && grant_cnt < c_cnt_w'(WR_PORT_NUM)) begin
                    port_sel            = grant_cnt[c_port_w-1:0];
                    rdy[scan_pos]       = 1'b1;
                    wr_en_d[port_sel]   = 1'b1;
                    wr_idx_d[port_sel]  = req_if.v_req_index[scan_pos];
                    wr_data_d[port_sel] = req_if.v_req_data[scan_pos];
                    last_grant          = scan_pos;
                    grant_cnt           = grant_cnt + c_cnt_w'(1);
                end
            end
        end

        // Next scan starts just past the last winner; drops never move it.
        rr_ptr_d = rr_ptr_q;
        if (grant_cnt != '0) begin
            rr_ptr_d = (last_grant == c_ptr_w'(REQ_NUM - 1)) ? '0 : last_grant + c_ptr_w'(1);
        end

        wr_sum     = {1'b0, wr_cnt_q} + 33'(grant_cnt);
        drop_sum   = {1'b0, drop_cnt_q} + 33'(drop_num);
        wr_cnt_d   = wr_sum[32] ? '1 : wr_sum[31:0];
        drop_cnt_d = drop_sum[32] ? '1 : drop_sum[31:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q   <= '0;
            wr_en_q    <= '0;
            wr_idx_q   <= '0;
            wr_data_q  <= '0;
            wr_cnt_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            wr_en_q    <= wr_en_d;
            wr_idx_q   <= wr_idx_d;
            wr_data_q  <= wr_data_d;
            wr_cnt_q   <= wr_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign req_if.v_req_rdy = rdy;
    assign v_wr_en          = wr_en_q;
    assign v_wr_reg_index   = wr_idx_q;
    assign v_wr_reg_data    = wr_data_q;
    assign wr_cnt           = wr_cnt_q;
    assign drop_cnt         = drop_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_toy_regfile_wb_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_toy_regfile_wb_arbiter                             |
// | Brief    : Directed bench for an INT (u0) and FP (u1) arbiter.   |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module tb_toy_regfile_wb_arbiter;
    localparam int RN = 6;
    localparam int WP = 4;
    localparam int IW = 6;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic stall = 1'b0;
    logic [RN-1:0]         vld;
    logic [RN-1:0][IW-1:0] idx;
    logic [RN-1:0][DW-1:0] dat;
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    toy_regfile_wb_arbiter_if #(.REQ_NUM(RN), .PHY_REG_ID_WIDTH(IW), .REG_WIDTH(DW)) bus0 ();
    toy_regfile_wb_arbiter_if #(.REQ_NUM(RN), .PHY_REG_ID_WIDTH(IW), .REG_WIDTH(DW)) bus1 ();
    assign bus0.v_req_vld   = vld;
    assign bus0.v_req_index = idx;
    assign bus0.v_req_data  = dat;
    assign bus1.v_req_vld   = vld;
    assign bus1.v_req_index = idx;
    assign bus1.v_req_data  = dat;

    logic [WP-1:0]         en0, en1;
    logic [WP-1:0][IW-1:0] oi0, oi1;
    logic [WP-1:0][DW-1:0] od0, od1;
    logic [31:0]           wc0, wc1, dc0, dc1;

    toy_regfile_wb_arbiter #(.REQ_NUM(RN), .WR_PORT_NUM(WP), .MODE(0), .PHY_REG_ID_WIDTH(IW), .REG_WIDTH(DW)) u0 (
        .clk(clk), .rst_n(rst_n), .req_if(bus0.slave), .wb_stall(stall),
        .v_wr_en(en0), .v_wr_reg_index(oi0), .v_wr_reg_data(od0), .wr_cnt(wc0), .drop_cnt(dc0));
    toy_regfile_wb_arbiter #(.REQ_NUM(RN), .WR_PORT_NUM(WP), .MODE(1), .PHY_REG_ID_WIDTH(IW), .REG_WIDTH(DW)) u1 (
        .clk(clk), .rst_n(rst_n), .req_if(bus1.slave), .wb_stall(stall),
        .v_wr_en(en1), .v_wr_reg_index(oi1), .v_wr_reg_data(od1), .wr_cnt(wc1), .drop_cnt(dc1));

    logic [WP-1:0]         a_en  [2];
    logic [WP-1:0][IW-1:0] a_idx [2];
    logic [WP-1:0][DW-1:0] a_dat [2];
    logic [31:0]           a_wr  [2];
    logic [31:0]           a_drop[2];
    logic [RN-1:0]         a_rdy [2];
    int                    a_rr  [2];
    assign a_en[0] = en0;   assign a_en[1] = en1;
    assign a_idx[0] = oi0;  assign a_idx[1] = oi1;
    assign a_dat[0] = od0;  assign a_dat[1] = od1;
    assign a_wr[0] = wc0;   assign a_wr[1] = wc1;
    assign a_drop[0] = dc0; assign a_drop[1] = dc1;
    assign a_rdy[0] = bus0.v_req_rdy;
    assign a_rdy[1] = bus1.v_req_rdy;
    assign a_rr[0] = int'(u0.rr_ptr_q);
    assign a_rr[1] = int'(u1.rr_ptr_q);

    // Reference model: current registered state (m_*) and next state (n_*).
    int                    m_rr  [2], n_rr  [2];
    logic [WP-1:0]         m_en  [2], n_en  [2];
    logic [WP-1:0][IW-1:0] m_idx [2], n_idx [2];
    logic [WP-1:0][DW-1:0] m_dat [2], n_dat [2];
    longint                m_wr  [2], n_wr  [2];
    longint                m_drop[2], n_drop[2];
    logic [RN-1:0]         e_rdy [2];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic longint sat32(input longint v);
        return (v > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : v;
    endfunction

    task automatic model_reset(input int m);
        m_rr[m] = 0; m_en[m] = '0; m_idx[m] = '0; m_dat[m] = '0;
        m_wr[m] = 0; m_drop[m] = 0;
    endtask

    // Instance 0 runs in INT mode (reg-0 dropped), instance 1 in FP mode.
    task automatic model_eval(input int m);
        int q[$];
        int pos;
        int ndrop;
        ndrop = 0;
        e_rdy[m] = '0; n_en[m] = '0;
        n_idx[m] = m_idx[m]; n_dat[m] = m_dat[m]; n_rr[m] = m_rr[m];
        if (rst_n && !stall) begin
            for (int s = 0; s < RN; s++) begin
                pos = (m_rr[m] + s) % RN;
                if (vld[pos]) begin
                    if (m == 0 && idx[pos] == 0) begin
                        ndrop++;
                        e_rdy[m][pos] = 1'b1;
                    end else if (q.size() < WP) begin
                        q.push_back(pos);
                    end
                end
            end
            foreach (q[k]) begin
                e_rdy[m][q[k]] = 1'b1;
                n_en[m][k]     = 1'b1;
                n_idx[m][k]    = idx[q[k]];
                n_dat[m][k]    = dat[q[k]];
            end
            if (q.size() > 0) n_rr[m] = (q[q.size()-1] + 1) % RN;
        end
        n_wr[m]   = sat32(m_wr[m] + longint'(q.size()));
        n_drop[m] = sat32(m_drop[m] + longint'(ndrop));
    endtask

    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (!rst_n) model_reset(m);
            model_eval(m);
            chk($sformatf("u%0d_rdy", m),  a_rdy[m],  e_rdy[m]);
            chk($sformatf("u%0d_en", m),   a_en[m],   m_en[m]);
            chk($sformatf("u%0d_idx", m),  a_idx[m],  m_idx[m]);
            chk($sformatf("u%0d_data", m), a_dat[m],  m_dat[m]);
            chk($sformatf("u%0d_wr", m),   a_wr[m],   m_wr[m]);
            chk($sformatf("u%0d_drop", m), a_drop[m], m_drop[m]);
            chk($sformatf("u%0d_rr", m),   a_rr[m],   m_rr[m]);
        end
    end

    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (!rst_n) model_reset(m);
            else begin
                m_rr[m] = n_rr[m]; m_en[m] = n_en[m]; m_idx[m] = n_idx[m];
                m_dat[m] = n_dat[m]; m_wr[m] = n_wr[m]; m_drop[m] = n_drop[m];
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vld = '0;
        for (int i = 0; i < RN; i++) begin
            idx[i] = IW'(i + 1);
            dat[i] = 32'hA000_0000 + 32'(i);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_en", en0, 4'b0000);
        chk("rst_idx", oi0, 24'h0);
        chk("rst_rdy", bus0.v_req_rdy, 6'b000000);
        chk("rst_wr", wc0, 32'd0);
        nxt(); rst_n = 1'b1;

        // Single request
        nxt(); idx[2] = 6'd17; dat[2] = 32'hDEAD_BEEF; vld = 6'b000100;
        @(negedge clk); chk("single_rdy", bus0.v_req_rdy, 6'b000100);
        nxt(); vld = '0;
        @(negedge clk);
        chk("single_en", en0, 4'b0001);
        chk("single_idx", oi0[0], 6'd17);
        chk("single_data", od0[0], 32'hDEAD_BEEF);
        chk("single_wr", wc0, 32'd1);
        chk("single_rr", u0.rr_ptr_q, 3'd3);

        // Oversubscription from rr_ptr = 0
        nxt(); vld = 6'b100000;
        nxt(); vld = 6'b111111;
        @(negedge clk);
        chk("over_rr0", u0.rr_ptr_q, 3'd0);
        chk("over_rdy0", bus0.v_req_rdy, 6'b001111);
        nxt(); vld = 6'b110000;
        @(negedge clk);
        chk("over_en0", en0, 4'b1111);
        chk("over_idx0", oi0, {6'd4, 6'd17, 6'd2, 6'd1});
        chk("over_rr1", u0.rr_ptr_q, 3'd4);
        chk("over_rdy1", bus0.v_req_rdy, 6'b110000);
        nxt(); vld = '0;
        @(negedge clk);
        chk("over_en1", en0, 4'b0011);
        chk("over_idx1", oi0[1:0], {6'd6, 6'd5});
        chk("over_rr2", u0.rr_ptr_q, 3'd0);
        chk("over_wr", wc0, 32'd8);

        // Wrap fairness from rr_ptr = 4
        nxt(); vld = 6'b001000;
        nxt(); vld = 6'b110011;
        @(negedge clk);
        chk("wrap_rr0", u0.rr_ptr_q, 3'd4);
        chk("wrap_rdy", bus0.v_req_rdy, 6'b110011);
        nxt(); vld = '0;
        @(negedge clk);
        chk("wrap_en", en0, 4'b1111);
        chk("wrap_idx", oi0, {6'd2, 6'd1, 6'd6, 6'd5});
        chk("wrap_rr1", u0.rr_ptr_q, 3'd2);
        chk("wrap_wr", wc0, 32'd13);

        // Zero filter, both modes, from rr_ptr = 0
        nxt(); vld = 6'b100000;
        nxt(); idx[1] = 6'd0; idx[3] = 6'd9; vld = 6'b001010;
        @(negedge clk);
        chk("zero_rdy_int", bus0.v_req_rdy, 6'b001010);
        chk("zero_rdy_fp", bus1.v_req_rdy, 6'b001010);
        nxt(); vld = '0;
        @(negedge clk);
        chk("zero_en_int", en0, 4'b0001);
        chk("zero_idx_int", oi0[0], 6'd9);
        chk("zero_drop_int", dc0, 32'd1);
        chk("zero_rr_int", u0.rr_ptr_q, 3'd4);
        chk("zero_wr_int", wc0, 32'd15);
        chk("zero_en_fp", en1, 4'b0011);
        chk("zero_idx_fp", oi1[1:0], {6'd9, 6'd0});
        chk("zero_drop_fp", dc1, 32'd0);
        chk("zero_wr_fp", wc1, 32'd16);

        // Stall for three cycles, then release
        nxt(); idx[1] = 6'd2; idx[3] = 6'd4; stall = 1'b1; vld = 6'b111111;
        repeat (3) begin
            @(negedge clk);
            chk("stall_rdy", bus0.v_req_rdy, 6'b000000);
            chk("stall_en", en0, 4'b0000);
            chk("stall_rr", u0.rr_ptr_q, 3'd4);
            chk("stall_wr", wc0, 32'd15);
            @(posedge clk);
        end
        #1 stall = 1'b0;
        @(negedge clk);
        chk("release_rdy", bus0.v_req_rdy, 6'b110011);

        // Reset while all four ports are writing
        nxt();
        chk("prereset_en", en0, 4'b1111);
        #1 rst_n = 1'b0;
        #1;
        chk("areset_en", en0, 4'b0000);
        chk("areset_idx", oi0, 24'h0);
        chk("areset_wr", wc0, 32'd0);
        chk("areset_drop", dc1, 32'd0);
        chk("areset_rdy", bus0.v_req_rdy, 6'b000000);
        @(negedge clk);
        nxt(); rst_n = 1'b1;
        @(negedge clk);
        chk("postreset_rdy", bus0.v_req_rdy, 6'b001111);
        nxt(); vld = '0;
        @(negedge clk);
        chk("postreset_en", en0, 4'b1111);
        chk("postreset_idx0", oi0[0], 6'd1);
        chk("postreset_rr", u0.rr_ptr_q, 3'd4);
        chk("postreset_wr", wc0, 32'd4);
        repeat (2) nxt();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end
endmodule
`default_nettype wire

// File: doc/toy_regfile_wb_arbiter.md
Name: toy_regfile_wb_arbiter

Overview:
- Shares the physical-regfile write ports among more writeback requesters than ports.
- Requesters are execution units, load return and CSR.
- Per cycle, grants up to WR_PORT_NUM requesters in round-robin order, packs them onto ports 0..k-1 and drives the regfile write ports from registers.
- Sits between the EU writeback buses and the physical regfile. In INT mode it also filters writes to physical reg 0.

Parameters:
- REQ_NUM, 6, number of writeback requesters (must be ≥ WR_PORT_NUM, ≤ 16).
- WR_PORT_NUM, EU_NUM (4), number of regfile write ports driven.
- MODE, 0, 0 = INT (phy reg 0 hardwired zero, writes to it dropped); 1 = FP (no filtering).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous reset, active-low.
- v_req_vld  in  REQ_NUM  writeback request valid per requester.
- v_req_index  in  PHY_REG_ID_WIDTH x REQ_NUM  destination physical reg id.
- v_req_data  in  REG_WIDTH x REQ_NUM  writeback data.
- v_req_rdy  out  REQ_NUM  request accepted this cycle (combinational).
- wb_stall  in  1  blocks all grants this cycle.
- v_wr_en  out  WR_PORT_NUM  regfile write enable (registered).
- v_wr_reg_index  out  PHY_REG_ID_WIDTH x WR_PORT_NUM  registered write index.
- v_wr_reg_data  out  REG_WIDTH x WR_PORT_NUM  registered write data.
- wr_cnt  out  32  total writes issued, saturating.
- drop_cnt  out  32  total reg-0 writes dropped, saturating.

Behaviour:
- Reset values: v_wr_en = 0, all v_wr_reg_index/data = 0, wr_cnt = drop_cnt = 0, rr_ptr = 0. v_req_rdy = 0 while rst_n is low.
- Transfer occurs on v_req_vld[i] & v_req_rdy[i]. A requester holds vld/index/data stable until accepted. The arbiter never depends on rdy-before-vld.
- Zero filter (MODE=0 only):
  - A valid request with index 0 is "zero-drop".
  - v_req_rdy = 1 whenever the request is valid and wb_stall = 0.
  - It consumes no port and no rr slot, produces no write, and increments drop_cnt.
  - MODE=1 treats index 0 as a normal request.
- Arbitration (combinational, same cycle):
  - If wb_stall = 1, all rdy = 0 (including zero-drop) and no grants.
  - Otherwise scan requesters in circular order rr_ptr, rr_ptr+1, …, rr_ptr+REQ_NUM-1 (mod REQ_NUM).
  - The first WR_PORT_NUM non-drop valid requesters are granted. The k-th granted maps to port k (k = 0..WR_PORT_NUM-1).
  - Ungranted valid requesters see rdy = 0.
- Output stage: on the next clk edge, v_wr_en[k] <= 1 for each port with a grant, else 0.
  - Index/data are loaded only for enabled ports; disabled ports hold their previous value.
  - Latency: request accepted in cycle N → regfile write strobe visible in cycle N+1.
- rr_ptr update:
  - If ≥1 grant, rr_ptr <= (index of last granted requester + 1) mod REQ_NUM.
  - With no grants (including stall), rr_ptr is unchanged. Zero-drop never moves rr_ptr.
  - This guarantees each continuously-valid requester is granted within ceil(REQ_NUM/WR_PORT_NUM) non-stalled cycles.
- Duplicate indices: two requesters with the same non-zero index in one cycle are both granted if within the port budget. Both writes are issued; the regfile's port priority decides. The arbiter does not merge them.
- wr_cnt adds the number of grants each cycle. drop_cnt adds the number of zero-drops. Both saturate at 0xFFFF_FFFF.
- Reset asserted mid-operation: outputs clear asynchronously and in-flight registered writes are discarded. Requesters must re-present after reset.

Test Plan:
- Single request: REQ_NUM=6, WR_PORT_NUM=4, MODE=0, only req 2 valid with index 17, data 0xDEAD_BEEF → rdy[2] = 1 in cycle N. In cycle N+1: v_wr_en = 4'b0001, port0 index 17, data 0xDEAD_BEEF, wr_cnt = 1, rr_ptr = 3.
- Oversubscription: all 6 valid and held from rr_ptr = 0:
  - cycle 0: grants req 0-3 on ports 0-3, rr_ptr = 4;
  - cycle 1: grants req 4, 5 on ports 0, 1 (after re-presenting only 4, 5), rr_ptr = 0;
  - wr_cnt = 6.
- Wrap fairness: rr_ptr = 4, req 0, 1, 4, 5 valid → port0 = req4, port1 = req5, port2 = req0, port3 = req1; next rr_ptr = 2.
- Zero filter: MODE=0, req 1 index 0 and req 3 index 9 valid → both rdy. Only port0 writes index 9, drop_cnt = 1, rr_ptr = 4. Repeat with MODE=1 → two writes, index 0 on port0.
- Stall: all valid with wb_stall = 1 for 3 cycles → rdy = 0, v_wr_en = 0, rr_ptr and counters unchanged. Release → normal grants from the same rr_ptr.
- Reset mid-stream: assert rst_n low while v_wr_en = 4'b1111 → outputs 0 immediately. After release, first grant starts at req 0.
